// File: rtl/flappy_pkg.sv
//==============================================================================
// Module      : flappy_pkg
// Description : Shared board geometry, scroll states and LFSR constants.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package flappy_pkg;

    localparam int ROWS = 15;
    localparam int COLS = 16;

    typedef logic [ROWS-1:0] col_t;

    localparam int ST_W = 2;
    typedef logic [ST_W-1:0] state_t;

    localparam state_t c_IDLE   = 2'd0;
    localparam state_t c_SCROLL = 2'd1;
    localparam state_t c_FROZEN = 2'd2;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // x^8+x^6+x^5+x^4+1 taps state bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

`default_nettype wire

// File: rtl/gap_lfsr.sv
//==============================================================================
// Module      : gap_lfsr
// Description : 8-bit Fibonacci LFSR choosing the gap offset of each new pipe.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module gap_lfsr
    import flappy_pkg::*;
#(
    parameter logic [7:0] SEED    = LFSR_SEED,
    parameter int          GAP_MIN = 2,
    parameter int          OFF_W   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_adv,
    output logic [OFF_W-1:0] o_gap_off
);

    logic [7:0] r_lfsr;
    logic       w_fb;

    assign w_fb = ^(r_lfsr & LFSR_TAPS);

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_lfsr <= SEED;
        end else if (i_adv) begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
        end
    end

    // Offset reflects the current state; it is consumed on the same edge the LFSR advances
    assign o_gap_off = OFF_W'(GAP_MIN) + OFF_W'(r_lfsr[2:0]);

endmodule

`default_nettype wire

// File: rtl/pipe_scroller.sv
//==============================================================================
// Module      : pipe_scroller
// Description : Scrolling pipe field; shifts columns left and inserts pipes.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pipe_scroller #(
    parameter int          ROWS         = flappy_pkg::ROWS,
    parameter int          COLS         = flappy_pkg::COLS,
    parameter int          BIRD_COL     = 3,
    parameter int          MOVE_PERIOD  = 176,
    parameter int          PIPE_SPACING = 4,
    parameter int          GAP_H        = 4,
    parameter int          GAP_MIN      = 2,
    parameter logic [7:0]  LFSR_SEED    = flappy_pkg::LFSR_SEED
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 freeze,
    output logic [ROWS-1:0]      col_bird,
    output logic [COLS*ROWS-1:0] frame,
    output logic                 move,
    output logic                 busy
);

    import flappy_pkg::*;

    localparam int c_OFF_W  = $clog2(ROWS) + 1;
    localparam int c_TICK_W = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
    localparam int c_SPC_W  = (PIPE_SPACING > 1) ? $clog2(PIPE_SPACING) : 1;

    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(MOVE_PERIOD - 1);
    localparam logic [c_SPC_W-1:0]  c_SPC_LOAD  = c_SPC_W'(PIPE_SPACING - 1);

    state_t              r_state;
    logic [c_TICK_W-1:0] r_tick;
    logic [c_SPC_W-1:0]  r_space;
    logic [ROWS-1:0]     r_cols [COLS];
    logic                r_move;
    logic                r_busy;

    logic                w_shift;
    logic                w_adv;
    logic                w_clr;
    logic [c_OFF_W-1:0]  w_gap_off;
    logic [ROWS-1:0]     w_pipe;
    logic [ROWS-1:0]     w_insert;

    always_comb begin
        w_shift = (r_state == c_SCROLL) && run && !freeze && (r_tick == c_TICK_LAST);
        w_adv   = w_shift && (r_space == '0);
        w_clr   = (r_state == c_IDLE) || ((r_state == c_SCROLL) && !run && !freeze);
    end

    gap_lfsr #(
        .SEED    (LFSR_SEED),
        .GAP_MIN (GAP_MIN),
        .OFF_W   (c_OFF_W)
    ) u_gap_lfsr (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (w_clr),
        .i_adv     (w_adv),
        .o_gap_off (w_gap_off)
    );

    always_comb begin
        w_pipe = '0;
        for (int r = 0; r < ROWS; r++) begin
            w_pipe[r] = !((r >= int'(w_gap_off)) && (r < int'(w_gap_off) + GAP_H));
        end
        w_insert = (r_space == '0) ? w_pipe : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_tick  <= '0;
            r_space <= '0;
            r_move  <= 1'b0;
            r_busy  <= 1'b0;
            for (int i = 0; i < COLS; i++) begin
                r_cols[i] <= '0;
            end
        end else begin
            r_move <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_tick  <= '0;
                    r_space <= '0;
                    for (int i = 0; i < COLS; i++) begin
                        r_cols[i] <= '0;
                    end
                    if (run && !freeze) begin
                        r_state <= c_SCROLL;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                c_SCROLL: begin
                    // freeze outranks both the tick wrap and a run drop
                    if (freeze) begin
                        r_state <= c_FROZEN;
                        r_busy  <= 1'b0;
                    end else if (!run) begin
                        r_state <= c_IDLE;
                        r_busy  <= 1'b0;
                        r_tick  <= '0;
                        r_space <= '0;
                        for (int i = 0; i < COLS; i++) begin
                            r_cols[i] <= '0;
                        end
                    end else if (w_shift) begin
                        r_tick <= '0;
                        r_move <= 1'b1;
                        for (int i = 0; i < COLS - 1; i++) begin
                            r_cols[i] <= r_cols[i+1];
                        end
                        r_cols[COLS-1] <= w_insert;
                        if (r_space == '0) begin
                            r_space <= c_SPC_LOAD;
                        end else begin
                            r_space <= r_space - 1'b1;
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                c_FROZEN: begin
                    r_busy <= 1'b0;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    generate
        for (genvar c = 0; c < COLS; c++) begin : g_frame
            assign frame[c*ROWS +: ROWS] = r_cols[c];
        end
    endgenerate

    assign col_bird = r_cols[BIRD_COL];
    assign move     = r_move;
    assign busy     = r_busy;

endmodule

`default_nettype wire

// File: doc/pipe_scroller.md
Name: pipe_scroller

Overview:
- Produces the scrolling pipe field for the LED-matrix Flappy Bird game. It is the source of the column mask that the collision checker consumes.
- Holds COLS column masks of ROWS bits each and shifts them one column left every MOVE_PERIOD clocks. On each shift it inserts either a new pipe or an empty column at the right edge.
- Exports the mask at the bird's column for collision/scoring and the full frame for the display driver.

Parameters:
- ROWS, 15, bits per column mask; must match the birdloc width.
- COLS, 16, number of board columns held.
- BIRD_COL, 3, column index sampled for col_bird.
- MOVE_PERIOD, 176, clocks per scroll step. Use 9 in simulation.
- PIPE_SPACING, 4, scroll steps between pipe insertions.
- GAP_H, 4, opening height in rows.
- GAP_MIN, 2, lowest gap row. Constraint: GAP_MIN+7+GAP_H <= ROWS-1.
- LFSR_SEED, 8'hA5, reset value of the gap LFSR.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- run  in  1  game active; high = scrolling allowed
- freeze  in  1  game over (collision checker's loser); halts scrolling
- col_bird  out  ROWS  mask of column BIRD_COL (1 = pipe present)
- frame  out  COLS*ROWS  all columns flattened; column c occupies bits [c*ROWS +: ROWS]
- move  out  1  one-cycle pulse, high the cycle after each shift
- busy  out  1  high in SCROLL state

Behaviour:
- Column 0 is leftmost; row bit 0 is the bottom row. All outputs are registered.
- Reset values: all columns 0, col_bird=0, frame=0, move=0, busy=0. Tick counter=0, spacing counter=0, LFSR=LFSR_SEED, state=IDLE.
- Reset mid-operation returns to the reset values on the next edge, regardless of run/freeze.
- States:
  - IDLE: board held at zero, counters at reset values. Transition to SCROLL when run=1 and freeze=0.
  - SCROLL: tick counter increments each clock. When it equals MOVE_PERIOD-1, it wraps to 0 and a shift occurs on that edge.
  - FROZEN: entered from SCROLL when freeze=1. Columns, tick counter, spacing counter and LFSR all hold. move=0. Exits only via reset.
  - Any state except FROZEN: run=0 returns to IDLE and clears the board and counters.
- Shift: col[i] <= col[i+1] for i in 0..COLS-2. Column 0's old content is discarded. col[COLS-1] <= insertion column.
- Insertion column:
  - If spacing counter == 0: insert a pipe, reload spacing counter with PIPE_SPACING-1, then advance the LFSR.
  - Otherwise: insert all zeros and decrement the spacing counter.
  - The first shift after leaving IDLE therefore inserts a pipe.
- Pipe mask: bit r = 0 when GAP_OFF <= r < GAP_OFF+GAP_H, else 1.
  - GAP_OFF = GAP_MIN + lfsr[2:0], using the LFSR value before it advances.
  - Width rule: GAP_OFF is computed at $clog2(ROWS)+1 bits; no wrap is possible given the parameter constraint.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0. It never reaches all-zero from a nonzero seed.
- move: asserted for exactly one clock, the cycle after the shift edge. It is never asserted in IDLE or FROZEN.
- col_bird and frame reflect the columns after a shift on the same cycle move is high, i.e. one register stage after the column array updates.
- Simultaneous events:
  - freeze=1 on the same cycle as a tick wrap: freeze wins, no shift, enter FROZEN.
  - run=0 and freeze=1 together in SCROLL: freeze wins.
- Latency: a pipe inserted on shift k appears at BIRD_COL on shift k+(COLS-1-BIRD_COL), which is 12 shifts with the defaults.

Decomposition:
- Shared package flappy_pkg:
  - ROWS and COLS constants.
  - col_t typedef (logic [ROWS-1:0]).
  - scroll state enum (IDLE, SCROLL, FROZEN).
  - LFSR seed and tap constants.
- One natural sub-module: gap_lfsr (advance enable in; 8-bit state and GAP_OFF out).
- The pipe-mask generation and shift register stay in pipe_scroller.

Test Plan:
- Reset with run=1, then run held for MOVE_PERIOD=9 -> move first pulses on clock 10 after reset release; frame bits [239:225] = 15'h787F (seed A5 gives GAP_OFF=7, rows 7..10 open); all other columns zero.
- Run 12 further shifts -> col_bird = 15'h787F exactly on the 13th move pulse. The next pipe reaches col_bird 4 shifts later with a different mask derived from the next LFSR state, verified against a reference LFSR model.
- Count insertions over 40 shifts -> pipe columns at shifts 1,5,9,...,37 only; every pipe mask has exactly GAP_H=4 contiguous zeros with GAP_OFF in 2..9.
- Assert freeze on the same cycle as a tick wrap -> no shift, move stays 0, frame and col_bird unchanged for 50 clocks, busy=0. Deasserting freeze and pulsing run does not resume scrolling.
- Assert reset mid-SCROLL with a populated board -> next cycle frame=0, col_bird=0, move=0. A restart reproduces the identical 15'h787F first pipe.
- Drop run to 0 mid-SCROLL -> board clears next cycle, state IDLE. Raising run restarts with a pipe at the first shift, using the reseeded LFSR.
